// File: rtl/switch_pkg.sv
// Shared types for the switch datapath blocks.
package switch_pkg;

    // Per-outport allocation state: free, or held by one inport until its tail leaves.
    typedef enum logic {
        SA_IDLE = 1'b0,
        SA_BUSY = 1'b1
    } sa_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i wins,
// scanning upward and wrapping modulo N.
module rr_arbiter #(
    parameter int  N = 4,
    localparam int W = $clog2(N) + ((N == 1) ? 1 : 0)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    logic [W:0]   sum;
    logic [W-1:0] cand;

    // Walk the N positions starting at ptr_i; the wrap is at N, not at 2^W.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (W+1)'(k);
            if (sum >= (W+1)'(N)) begin
                sum = sum - (W+1)'(N);
            end
            cand = sum[W-1:0];
            if (!any_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-packet output-port allocator. Each outport runs an IDLE/BUSY FSM with an
// owner register and a round-robin pointer; a won connection is held until the
// owner's tail flit is dequeued. All outputs decode registered state only.
//
// Handshake: req[i] is a level held by the input buffer until grant[i] rises;
// grant[i] stays high until the cycle after release_i[i] (a 1-cycle pulse) is
// sampled. out_sel[i] must be stable while req[i] is high.
module switch_allocator
    import switch_pkg::*;
#(
    parameter int  NUM_INPORTS  = 4,
    parameter int  NUM_OUTPORTS = 4,
    localparam int SELECT_SIZE  = $clog2(NUM_OUTPORTS) + ((NUM_OUTPORTS == 1) ? 1 : 0),
    localparam int IN_SEL_SIZE  = $clog2(NUM_INPORTS) + ((NUM_INPORTS == 1) ? 1 : 0)
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic [NUM_INPORTS-1:0]              req,
    input  logic [NUM_INPORTS*SELECT_SIZE-1:0]  out_sel,
    input  logic [NUM_INPORTS-1:0]              release_i,
    output logic [NUM_INPORTS-1:0]              grant,
    output logic [NUM_OUTPORTS*IN_SEL_SIZE-1:0] xbar_sel,
    output logic [NUM_OUTPORTS-1:0]             xbar_valid,
    output logic                                bad_sel
);

    logic bad_sel_q, bad_sel_d;

    // An inport is granted when any allocated outport names it as owner.
    // xbar_sel is already zero for idle outports, so valid gates the decode.
    always_comb begin
        grant = '0;
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            if (xbar_valid[o]) begin
                grant[xbar_sel[o*IN_SEL_SIZE +: IN_SEL_SIZE]] = 1'b1;
            end
        end
    end

    // Flag any waiting request that names an outport that does not exist.
    always_comb begin
        bad_sel_d = 1'b0;
        for (int i = 0; i < NUM_INPORTS; i++) begin
            if (req[i] && !grant[i] &&
                (int'(out_sel[i*SELECT_SIZE +: SELECT_SIZE]) >= NUM_OUTPORTS)) begin
                bad_sel_d = 1'b1;
            end
        end
    end

    // Registered bad_sel pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bad_sel_q <= 1'b0;
        end else begin
            bad_sel_q <= bad_sel_d;
        end
    end

    assign bad_sel = bad_sel_q;

    for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_out
        sa_state_t              state_q, state_d;
        logic [IN_SEL_SIZE-1:0] owner_q, owner_d;
        logic [IN_SEL_SIZE-1:0] rr_ptr_q, rr_ptr_d;
        logic [IN_SEL_SIZE-1:0] arb_idx;
        logic [NUM_INPORTS-1:0] cand;
        logic [NUM_INPORTS-1:0] arb_gnt;
        logic                   arb_any;
        logic                   unused_arb_gnt;

        // Eligible inports: requesting, not already holding a port, aimed at this outport.
        always_comb begin
            cand = '0;
            for (int i = 0; i < NUM_INPORTS; i++) begin
                cand[i] = req[i] && !grant[i] &&
                          (out_sel[i*SELECT_SIZE +: SELECT_SIZE] == SELECT_SIZE'(o));
            end
        end

        rr_arbiter #(.N(NUM_INPORTS)) u_arb (
            .req_i (cand),
            .ptr_i (rr_ptr_q),
            .gnt_o (arb_gnt),
            .idx_o (arb_idx),
            .any_o (arb_any)
        );

        // Only the encoded winner is needed to load the owner register.
        assign unused_arb_gnt = ^arb_gnt;

        // Next state: allocate from IDLE, free on the owner's release. Because
        // IDLE is always visited for a cycle, a freed outport cannot be re-won
        // on the same edge it is released.
        always_comb begin
            state_d  = state_q;
            owner_d  = owner_q;
            rr_ptr_d = rr_ptr_q;
            case (state_q)
                SA_IDLE: begin
                    if (arb_any) begin
                        state_d  = SA_BUSY;
                        owner_d  = arb_idx;
                        rr_ptr_d = (arb_idx == IN_SEL_SIZE'(NUM_INPORTS - 1))
                                   ? '0 : arb_idx + IN_SEL_SIZE'(1);
                    end
                end
                SA_BUSY: begin
                    if (release_i[owner_q]) begin
                        state_d = SA_IDLE;
                    end
                end
                default: begin
                    state_d = SA_IDLE;
                end
            endcase
        end

        // State, owner and pointer registers; reset abandons any held connection.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                state_q  <= SA_IDLE;
                owner_q  <= '0;
                rr_ptr_q <= '0;
            end else begin
                state_q  <= state_d;
                owner_q  <= owner_d;
                rr_ptr_q <= rr_ptr_d;
            end
        end

        // Crossbar drive: owner while allocated, zero while idle.
        assign xbar_valid[o]                          = (state_q == SA_BUSY);
        assign xbar_sel[o*IN_SEL_SIZE +: IN_SEL_SIZE] = (state_q == SA_BUSY) ? owner_q : '0;
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: a 4x4 instance for allocation, contention,
// wrap-around, release and reset behaviour, and a 4x3 instance for bad selects.
module tb_switch_allocator;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic n_rst;

    // 4 inports x 4 outports
    logic [3:0] req, rel, grant, xv;
    logic [7:0] sel, xs;
    logic       bs;

    // 4 inports x 3 outports
    logic [3:0] req3, rel3, g3;
    logic [7:0] sel3;
    logic [5:0] xs3;
    logic [2:0] xv3;
    logic       bs3;

    int n_assert = 0;
    int n_fail   = 0;

    switch_allocator #(.NUM_INPORTS(4), .NUM_OUTPORTS(4)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .req        (req),
        .out_sel    (sel),
        .release_i  (rel),
        .grant      (grant),
        .xbar_sel   (xs),
        .xbar_valid (xv),
        .bad_sel    (bs)
    );

    switch_allocator #(.NUM_INPORTS(4), .NUM_OUTPORTS(3)) dut3 (
        .clk        (clk),
        .n_rst      (n_rst),
        .req        (req3),
        .out_sel    (sel3),
        .release_i  (rel3),
        .grant      (g3),
        .xbar_sel   (xs3),
        .xbar_valid (xv3),
        .bad_sel    (bs3)
    );

    // Pack per-inport outport selects, inport 0 in the low bits.
    function automatic logic [7:0] sel4(input logic [1:0] a0, input logic [1:0] a1,
                                        input logic [1:0] a2, input logic [1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver for the 4x4 instance.
    task automatic drive(input logic [3:0] r, input logic [7:0] s, input logic [3:0] rl);
        req = r;
        sel = s;
        rel = rl;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic [3:0] g,
                              input logic [3:0] v, input logic [7:0] s);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_valid"}, 32'(xv), 32'(v));
        check({tag, "_xsel"},  32'(xs), 32'(s));
    endtask

    initial begin
        n_rst = 1'b0;
        drive(4'b1111, sel4(2'd0, 2'd1, 2'd2, 2'd3), 4'b0000);
        req3 = 4'b0000;
        sel3 = 8'h00;
        rel3 = 4'b0000;

        // Reset held with all inports requesting: nothing allocates.
        tick();
        tick();
        check_main("rst_hold", 4'b0000, 4'b0000, 8'h00);
        check("rst_hold_bad", 32'(bs), 32'd0);

        // Reset released: each outport taken by the inport that names it.
        n_rst = 1'b1;
        tick();
        check_main("rst_alloc", 4'b1111, 4'b1111, 8'hE4);
        check("rst_alloc_bad", 32'(bs), 32'd0);

        // Free outport 3, leaving three outports busy.
        drive(4'b0000, sel4(2'd0, 2'd1, 2'd2, 2'd3), 4'b1000);
        tick();
        check_main("rel3", 4'b0111, 4'b0111, 8'h24);
        rel = 4'b0000;

        // Asynchronous reset mid-packet: outputs clear without a clock edge.
        #2;
        n_rst = 1'b0;
        #1;
        check_main("async_rst", 4'b0000, 4'b0000, 8'h00);
        check("async_rst_bad", 32'(bs), 32'd0);
        tick();
        tick();
        n_rst = 1'b1;

        // Contention: inports 0, 2, 3 on outport 1, pointer at 0.
        drive(4'b1101, sel4(2'd1, 2'd0, 2'd1, 2'd1), 4'b0000);
        tick();
        check_main("cont_first", 4'b0001, 4'b0010, 8'h00);
        drive(4'b1100, sel4(2'd1, 2'd0, 2'd1, 2'd1), 4'b0001);
        tick();
        check_main("cont_idle0", 4'b0000, 4'b0000, 8'h00);
        rel = 4'b0000;
        tick();
        check_main("cont_second", 4'b0100, 4'b0010, 8'h08);
        drive(4'b1000, sel4(2'd1, 2'd0, 2'd1, 2'd1), 4'b0100);
        tick();
        check_main("cont_idle1", 4'b0000, 4'b0000, 8'h00);
        rel = 4'b0000;
        tick();
        check_main("cont_third", 4'b1000, 4'b0010, 8'h0C);

        // Release from a non-owner leaves the connection in place.
        drive(4'b0000, sel4(2'd1, 2'd0, 2'd1, 2'd1), 4'b0001);
        tick();
        check_main("nonowner_rel", 4'b1000, 4'b0010, 8'h0C);
        rel = 4'b1000;
        tick();
        check_main("cont_done", 4'b0000, 4'b0000, 8'h00);
        rel = 4'b0000;

        // Move outport 2 pointer to 3 via inport 2.
        drive(4'b0100, sel4(2'd0, 2'd0, 2'd2, 2'd0), 4'b0000);
        tick();
        check_main("ptr_setup", 4'b0100, 4'b0100, 8'h20);
        drive(4'b0000, sel4(2'd0, 2'd0, 2'd2, 2'd0), 4'b0100);
        tick();
        check_main("ptr_setup_rel", 4'b0000, 4'b0000, 8'h00);
        rel = 4'b0000;

        // Wrap-around: pointer 3, inports 0 and 1 request -> inport 0 wins.
        drive(4'b0011, sel4(2'd2, 2'd2, 2'd0, 2'd0), 4'b0000);
        tick();
        check_main("wrap_win0", 4'b0001, 4'b0100, 8'h00);

        // Inport 0 releases and re-requests in the same cycle; pointer is now 1,
        // so inport 1 wins once the idle cycle passes.
        drive(4'b0011, sel4(2'd2, 2'd2, 2'd0, 2'd0), 4'b0001);
        tick();
        check_main("wrap_idle", 4'b0000, 4'b0000, 8'h00);
        rel = 4'b0000;
        tick();
        check_main("wrap_win1", 4'b0010, 4'b0100, 8'h10);

        // Inport 0 waits, then withdraws; it is never granted.
        drive(4'b0001, sel4(2'd2, 2'd2, 2'd0, 2'd0), 4'b0000);
        tick();
        check_main("withdraw_wait", 4'b0010, 4'b0100, 8'h10);
        drive(4'b0000, sel4(2'd2, 2'd2, 2'd0, 2'd0), 4'b0010);
        tick();
        check_main("withdraw_rel", 4'b0000, 4'b0000, 8'h00);
        rel = 4'b0000;
        tick();
        check_main("withdraw_idle", 4'b0000, 4'b0000, 8'h00);

        // Pointer still 2: inports 0 and 3 request outport 2 -> inport 3 wins.
        drive(4'b1001, sel4(2'd2, 2'd0, 2'd0, 2'd2), 4'b0000);
        tick();
        check_main("ptr_kept", 4'b1000, 4'b0100, 8'h30);
        drive(4'b0000, sel4(2'd2, 2'd0, 2'd0, 2'd2), 4'b1000);
        tick();
        check_main("final_rel", 4'b0000, 4'b0000, 8'h00);
        rel = 4'b0000;

        // Three outports: inport 1 names nonexistent outport 3.
        req3 = 4'b0010;
        sel3 = sel4(2'd0, 2'd3, 2'd0, 2'd0);
        check("bad_before", 32'(bs3), 32'd0);
        tick();
        check("bad_pulse1", 32'(bs3), 32'd1);
        check("bad_grant1", 32'(g3), 32'd0);
        check("bad_valid1", 32'(xv3), 32'd0);
        req3 = 4'b0011;
        sel3 = sel4(2'd2, 2'd3, 2'd0, 2'd0);
        tick();
        check("bad_pulse2", 32'(bs3), 32'd1);
        check("bad_grant2", 32'(g3), 32'b0001);
        check("bad_valid2", 32'(xv3), 32'b100);
        check("bad_xsel2", 32'(xs3), 32'd0);
        req3 = 4'b0000;
        tick();
        check("bad_clear", 32'(bs3), 32'd0);
        check("bad_hold_grant", 32'(g3), 32'b0001);
        check("main_bad_quiet", 32'(bs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
